// File: rtl/boxcar_decimator.sv
// boxcar_decimator: averages blocks of 2^L valid signed samples and emits one
// mean per block as a single-cycle tvalid pulse on an AXI-Stream master
// (no tready). A change of the clamped window size aborts the current block.
module boxcar_decimator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MAX_LOG_COUNT    = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [4:0]                  AV_log_count,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid
);

  // Accumulator has MAX_LOG_COUNT guard bits so a full window of extreme
  // samples cannot overflow; the counter needs one extra bit to reach 2^MAX.
  localparam int         ACC_W = AXIS_TDATA_WIDTH + MAX_LOG_COUNT;
  localparam int         CNT_W = MAX_LOG_COUNT + 1;
  localparam logic [4:0] MAX_L = 5'(MAX_LOG_COUNT);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Window sizes beyond what the accumulator supports fall back to the maximum.
  function automatic logic [4:0] clamp_log(input logic [4:0] l);
    return (l > MAX_L) ? MAX_L : l;
  endfunction

  // Block length 2^l as a counter value.
  function automatic logic [CNT_W-1:0] block_len(input logic [4:0] l);
    return CNT_W'(1) << l;
  endfunction

  // Mean of a completed block: arithmetic shift floors toward minus infinity;
  // the result always fits the sample width, so the upper bits are dropped.
  function automatic logic [AXIS_TDATA_WIDTH-1:0] block_mean(
    input logic signed [ACC_W-1:0] sum,
    input logic        [4:0]       l
  );
    logic signed [ACC_W-1:0] shifted;
    shifted = sum >>> l;
    return shifted[AXIS_TDATA_WIDTH-1:0];
  endfunction

  state_t                        state_q, state_d;
  logic [4:0]                    l_q, l_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                          tvalid_q, tvalid_d;

  logic [4:0]                    l_req;
  logic                          cfg_change;
  logic signed [ACC_W-1:0]       sample_ext;
  logic signed [ACC_W-1:0]       acc_sum;
  logic [CNT_W-1:0]              cnt_inc;

  // Decode the requested window size and form this cycle's running sum.
  always_comb begin
    l_req      = clamp_log(AV_log_count);
    cfg_change = (l_req != l_q);
    sample_ext = {{MAX_LOG_COUNT{S_AXIS_tdata[AXIS_TDATA_WIDTH-1]}}, S_AXIS_tdata};
    acc_sum    = acc_q + sample_ext;
    cnt_inc    = cnt_q + CNT_W'(1);
  end

  // Next-state logic; a config change overrides accumulation and completion.
  always_comb begin
    state_d  = state_q;
    l_d      = l_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tvalid_d = 1'b0;

    if (cfg_change) begin
      // The sample in this cycle is dropped and the partial window abandoned.
      l_d     = l_req;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (S_AXIS_tvalid) begin
            if (l_q == 5'd0) begin
              // A one-sample window completes on its first sample.
              tdata_d  = block_mean(sample_ext, l_q);
              tvalid_d = 1'b1;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = IDLE;
            end else begin
              acc_d   = sample_ext;
              cnt_d   = CNT_W'(1);
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (S_AXIS_tvalid) begin
            if (cnt_inc == block_len(l_q)) begin
              tdata_d  = block_mean(acc_sum, l_q);
              tvalid_d = 1'b1;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = IDLE;
            end else begin
              acc_d   = acc_sum;
              cnt_d   = cnt_inc;
              state_d = ACCUM;
            end
          end
        end
        default: begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      l_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      l_q      <= l_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tvalid = tvalid_q;

endmodule

// File: tb/tb_boxcar_decimator.sv
// Testbench for boxcar_decimator: a behavioural block-average model pushes
// expected results (value and arrival cycle) into a scoreboard as stimulus is
// driven; a monitor pops and compares on every output pulse.
module tb_boxcar_decimator;

  localparam int W = 32;

  logic         aclk   = 1'b0;
  logic         areset = 1'b1;
  logic [4:0]   av     = 5'd0;
  logic [W-1:0] sdata  = '0;
  logic         svalid = 1'b0;
  logic [W-1:0] mdata;
  logic         mvalid;

  always #5 aclk = ~aclk;

  boxcar_decimator #(
    .AXIS_TDATA_WIDTH(W),
    .MAX_LOG_COUNT   (16)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .AV_log_count (av),
    .S_AXIS_tdata (sdata),
    .S_AXIS_tvalid(svalid),
    .M_AXIS_tdata (mdata),
    .M_AXIS_tvalid(mvalid)
  );

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           cyc      = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  longint       m_sum    = 0;
  int           m_cnt    = 0;
  int           m_l      = 0;
  logic [W-1:0] last_out = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // Monitor: every pulse must match the oldest expectation in value and cycle;
  // between pulses the output data must hold.
  always @(negedge aclk) begin
    if (areset) begin
      last_out = '0;
    end else if (mvalid) begin
      chk("pulse_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("tdata", 64'(mdata), 64'(mon_e.data));
        chk("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
      last_out = mdata;
    end else begin
      chk("hold", 64'(mdata), 64'(last_out));
    end
  end

  // Drive one cycle of input and advance the reference model accordingly.
  task automatic send(input logic v, input logic [W-1:0] d);
    int     c;
    exp_t   e;
    svalid = v;
    sdata  = d;
    c = (av > 5'd16) ? 16 : int'(av);
    if (c != m_l) begin
      m_l   = c;
      m_sum = 0;
      m_cnt = 0;
    end else if (v) begin
      m_sum += longint'($signed(d));
      m_cnt++;
      if (m_cnt == (1 << m_l)) begin
        e.data = W'(m_sum >>> m_l);
        e.cyc  = cyc + 1;
        sb.push_back(e);
        m_sum = 0;
        m_cnt = 0;
      end
    end
    @(posedge aclk);
    #1;
    svalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, '0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset(input logic [4:0] new_l);
    #5;
    areset = 1'b1;
    #1;
    chk("rst_async_tvalid", 64'(mvalid), 64'd0);
    chk("rst_async_tdata", 64'(mdata), 64'd0);
    sb.delete();
    m_sum = 0;
    m_cnt = 0;
    m_l   = 0;
    av    = new_l;
    @(posedge aclk);
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_tvalid", 64'(mvalid), 64'd0);
    chk("reset_tdata", 64'(mdata), 64'd0);
    av = 5'd2;
    areset = 1'b0;

    // L=2: -20,-10,10,20 -> 0
    idle(2);
    send(1'b1, -32'sd20);
    send(1'b1, -32'sd10);
    send(1'b1, 32'sd10);
    send(1'b1, 32'sd20);
    idle(3);

    // L=2 floor: -1,-1,-1,0 -> -1 ; back-to-back 4,4,4,5 -> 4
    send(1'b1, -32'sd1);
    send(1'b1, -32'sd1);
    send(1'b1, -32'sd1);
    send(1'b1, 32'sd0);
    send(1'b1, 32'sd4);
    send(1'b1, 32'sd4);
    send(1'b1, 32'sd4);
    send(1'b1, 32'sd5);
    idle(2);

    // L=3 with a gap: mean 40/8 = 5
    av = 5'd3;
    idle(1);
    send(1'b1, -32'sd10);
    send(1'b1, -32'sd30);
    send(1'b1, -32'sd40);
    idle(3);
    send(1'b1, -32'sd20);
    send(1'b1, 32'sd10);
    send(1'b1, 32'sd20);
    send(1'b1, 32'sd30);
    send(1'b1, 32'sd80);
    idle(2);

    // L=0 pass-through, continuous tvalid
    av = 5'd0;
    idle(1);
    send(1'b1, 32'sd7);
    send(1'b1, -32'sd3);
    send(1'b1, 32'sd100);
    idle(2);

    // L=3 aborted after 5 samples; change-cycle sample discarded; L=1: 6,8 -> 7
    av = 5'd3;
    idle(1);
    for (int i = 1; i <= 5; i++) send(1'b1, W'(i));
    av = 5'd1;
    send(1'b1, 32'sd99);
    send(1'b1, 32'sd6);
    send(1'b1, 32'sd8);
    idle(2);

    // Config change on the block-completing sample: no pulse, then L=3 block of 16s
    av = 5'd2;
    idle(1);
    send(1'b1, 32'sd1);
    send(1'b1, 32'sd1);
    send(1'b1, 32'sd1);
    av = 5'd3;
    send(1'b1, 32'sd1);
    for (int i = 0; i < 8; i++) send(1'b1, 32'sd16);
    idle(2);

    // Reset while an output pulse is high
    av = 5'd1;
    idle(1);
    send(1'b1, 32'sd3);
    send(1'b1, 32'sd5);
    do_reset(5'd3);

    // Reset mid-window, then full L=16 window of max positive samples,
    // switching the request to 20 halfway (clamps to the same L)
    idle(1);
    send(1'b1, 32'sd5);
    send(1'b1, 32'sd6);
    send(1'b1, 32'sd7);
    do_reset(5'd16);
    idle(1);
    for (int i = 0; i < 32768; i++) send(1'b1, 32'h7FFF_FFFF);
    av = 5'd20;
    for (int i = 0; i < 32768; i++) send(1'b1, 32'h7FFF_FFFF);
    idle(3);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
